alu_operand_stage: RTL and testbench

//  ID->EX pipeline stage that buffers decoded instructions and drives the alu operand bus (A, B, ALUOp).
//  2-entry skid buffer: full throughput, registered in_ready_o, order preserved.

---
 rtl/alu_operand_stage.sv | 157 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: two-entry skid buffer with writeback forwarding and
// A/B operand selection feeding the alu.
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int OPW   = 5,
  parameter int REGAW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OPW-1:0]   in_alu_op_i,
  input  logic [REGAW-1:0] in_rs1_addr_i,
  input  logic [REGAW-1:0] in_rs2_addr_i,
  input  logic [XLEN-1:0]  in_rs1_data_i,
  input  logic [XLEN-1:0]  in_rs2_data_i,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic [XLEN-1:0]  in_imm_i,
  input  logic             in_a_sel_i,
  input  logic             in_b_sel_i,
  input  logic [REGAW-1:0] in_rd_i,
  input  logic             wb_en_i,
  input  logic [REGAW-1:0] wb_addr_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  alu_a_o,
  output logic [XLEN-1:0]  alu_b_o,
  output logic [OPW-1:0]   alu_op_o,
  output logic [REGAW-1:0] out_rd_o
);

  typedef struct packed {
    logic [OPW-1:0]   alu_op;
    logic [REGAW-1:0] rs1_addr;
    logic [REGAW-1:0] rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic             a_sel;
    logic             b_sel;
    logic [REGAW-1:0] rd;
  } entry_t;

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   ready_q;

  entry_t in_entry;
  entry_t in_fwd;
  entry_t main_fwd;
  entry_t skid_fwd;
  logic   accept;
  logic   consume;
  logic   main_free;

  // Same bypass rule serves fresh captures and entries already waiting; x0 is never replaced.
  function automatic entry_t forward(
    input entry_t           e,
    input logic             en,
    input logic [REGAW-1:0] addr,
    input logic [XLEN-1:0]  data
  );
    entry_t r;
    r = e;
    if (en && (addr != '0) && (addr == e.rs1_addr)) begin
      r.rs1_data = data;
    end
    if (en && (addr != '0) && (addr == e.rs2_addr)) begin
      r.rs2_data = data;
    end
    return r;
  endfunction

  always_comb begin
    in_entry          = '0;
    in_entry.alu_op   = in_alu_op_i;
    in_entry.rs1_addr = in_rs1_addr_i;
    in_entry.rs2_addr = in_rs2_addr_i;
    in_entry.rs1_data = in_rs1_data_i;
    in_entry.rs2_data = in_rs2_data_i;
    in_entry.pc       = in_pc_i;
    in_entry.imm      = in_imm_i;
    in_entry.a_sel    = in_a_sel_i;
    in_entry.b_sel    = in_b_sel_i;
    in_entry.rd       = in_rd_i;
  end

  always_comb begin
    in_fwd   = forward(in_entry, wb_en_i, wb_addr_i, wb_data_i);
    main_fwd = forward(main_q,   wb_en_i, wb_addr_i, wb_data_i);
    skid_fwd = forward(skid_q,   wb_en_i, wb_addr_i, wb_data_i);
  end

  assign accept    = in_valid_i & ready_q;
  assign consume   = main_valid & out_ready_i;
  assign main_free = ~main_valid | consume;

  // Ready is registered as the inverse of the next skid occupancy, so the
  // skid entry is always free whenever an accept can happen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else if (main_free) begin
      ready_q <= 1'b1;
      if (skid_valid) begin
        main_q     <= skid_fwd;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= in_fwd;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else begin
      main_q <= main_fwd;
      if (accept) begin
        skid_q     <= in_fwd;
        skid_valid <= 1'b1;
        ready_q    <= 1'b0;
      end else begin
        skid_q  <= skid_fwd;
        ready_q <= ~skid_valid;
      end
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid;

  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = '0;
    out_rd_o = '0;
    if (main_valid) begin
      alu_a_o  = main_q.a_sel ? main_q.pc  : main_q.rs1_data;
      alu_b_o  = main_q.b_sel ? main_q.imm : main_q.rs2_data;
      alu_op_o = main_q.alu_op;
      out_rd_o = main_q.rd;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed literal checks plus randomized traffic
// compared every cycle against a queue-based model of the stage.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [4:0]  in_alu_op_i;
  logic [4:0]  in_rs1_addr_i;
  logic [4:0]  in_rs2_addr_i;
  logic [31:0] in_rs1_data_i;
  logic [31:0] in_rs2_data_i;
  logic [31:0] in_pc_i;
  logic [31:0] in_imm_i;
  logic        in_a_sel_i;
  logic        in_b_sel_i;
  logic [4:0]  in_rd_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [4:0]  alu_op_o;
  logic [4:0]  out_rd_o;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .OPW(5), .REGAW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_alu_op_i(in_alu_op_i), .in_rs1_addr_i(in_rs1_addr_i), .in_rs2_addr_i(in_rs2_addr_i),
    .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i),
    .in_pc_i(in_pc_i), .in_imm_i(in_imm_i), .in_a_sel_i(in_a_sel_i), .in_b_sel_i(in_b_sel_i),
    .in_rd_i(in_rd_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o), .out_rd_o(out_rd_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage behaves as an in-order queue of at most two instructions.
  typedef struct {
    logic [4:0]  op;
    logic [4:0]  r1a;
    logic [4:0]  r2a;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        as;
    logic        bs;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];
  bit   m_ready = 0;
  bit   started = 0;

  always @(posedge clk) begin
    ent_t e;
    bit   acc;
    bit   con;
    if (!rst_n) begin
      q.delete();
      m_ready = 0;
      started = 1;
    end else if (flush_i) begin
      q.delete();
      m_ready = 1;
    end else begin
      acc = in_valid_i && m_ready;
      con = (q.size() > 0) && out_ready_i;
      if (con) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        if (wb_en_i && wb_addr_i != 0 && wb_addr_i == q[i].r1a) q[i].r1d = wb_data_i;
        if (wb_en_i && wb_addr_i != 0 && wb_addr_i == q[i].r2a) q[i].r2d = wb_data_i;
      end
      if (acc) begin
        e.op  = in_alu_op_i;
        e.r1a = in_rs1_addr_i;
        e.r2a = in_rs2_addr_i;
        e.r1d = (wb_en_i && wb_addr_i != 0 && wb_addr_i == in_rs1_addr_i) ? wb_data_i : in_rs1_data_i;
        e.r2d = (wb_en_i && wb_addr_i != 0 && wb_addr_i == in_rs2_addr_i) ? wb_data_i : in_rs2_data_i;
        e.pc  = in_pc_i;
        e.imm = in_imm_i;
        e.as  = in_a_sel_i;
        e.bs  = in_b_sel_i;
        e.rd  = in_rd_i;
        q.push_back(e);
      end
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea, eb;
    logic [4:0]  eop, erd;
    if (started) begin
      ea = 0; eb = 0; eop = 0; erd = 0;
      if (q.size() > 0) begin
        ea  = q[0].as ? q[0].pc  : q[0].r1d;
        eb  = q[0].bs ? q[0].imm : q[0].r2d;
        eop = q[0].op;
        erd = q[0].rd;
      end
      chk("model_valid", {31'b0, out_valid_o}, {31'b0, q.size() > 0});
      chk("model_ready", {31'b0, in_ready_o}, {31'b0, m_ready});
      chk("model_a", alu_a_o, ea);
      chk("model_b", alu_b_o, eb);
      chk("model_op", {27'b0, alu_op_o}, {27'b0, eop});
      chk("model_rd", {27'b0, out_rd_o}, {27'b0, erd});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] r1a, input logic [31:0] r1d,
                       input logic [4:0] r2a, input logic [31:0] r2d, input logic as,
                       input logic [31:0] pc, input logic bs, input logic [31:0] imm,
                       input logic [4:0] rd);
    in_valid_i    = 1'b1;
    in_alu_op_i   = op;
    in_rs1_addr_i = r1a;
    in_rs1_data_i = r1d;
    in_rs2_addr_i = r2a;
    in_rs2_data_i = r2d;
    in_a_sel_i    = as;
    in_pc_i       = pc;
    in_b_sel_i    = bs;
    in_imm_i      = imm;
    in_rd_i       = rd;
  endtask

  task automatic drain();
    in_valid_i  = 1'b0;
    wb_en_i     = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    cyc();
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_alu_op_i = '0; in_rs1_addr_i = '0; in_rs2_addr_i = '0;
    in_rs1_data_i = '0; in_rs2_data_i = '0; in_pc_i = '0; in_imm_i = '0;
    in_a_sel_i = 1'b0; in_b_sel_i = 1'b0; in_rd_i = '0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;

    repeat (3) cyc();
    chk("reset_valid", {31'b0, out_valid_o}, 32'd0);
    chk("reset_ready", {31'b0, in_ready_o}, 32'd0);
    chk("reset_a", alu_a_o, 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("release_ready", {31'b0, in_ready_o}, 32'd1);

    // single add
    out_ready_i = 1'b1;
    issue(5'd0, 5'd1, 32'd7, 5'd2, 32'd6, 1'b0, 32'h40, 1'b0, 32'h0, 5'd10);
    cyc();
    in_valid_i = 1'b0;
    chk("add_valid", {31'b0, out_valid_o}, 32'd1);
    chk("add_a", alu_a_o, 32'd7);
    chk("add_b", alu_b_o, 32'd6);
    chk("add_op", {27'b0, alu_op_o}, 32'd0);
    chk("add_sum", alu_a_o + alu_b_o, 32'd13);
    chk("add_rd", {27'b0, out_rd_o}, 32'd10);
    cyc();
    chk("add_gone", {31'b0, out_valid_o}, 32'd0);

    // pc / immediate select
    issue(5'd3, 5'd1, 32'd7, 5'd2, 32'd6, 1'b1, 32'h100, 1'b1, 32'hFFFF_FFFC, 5'd4);
    cyc();
    in_valid_i = 1'b0;
    chk("imm_a", alu_a_o, 32'h100);
    chk("imm_b", alu_b_o, 32'hFFFF_FFFC);
    drain();

    // backpressure
    out_ready_i = 1'b0;
    issue(5'd1, 5'd4, 32'h11, 5'd5, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1);
    cyc();
    issue(5'd2, 5'd6, 32'h22, 5'd7, 32'h2, 1'b0, 32'h0, 1'b0, 32'h0, 5'd2);
    cyc();
    in_valid_i = 1'b0;
    chk("bp_ready_low", {31'b0, in_ready_o}, 32'd0);
    chk("bp_i0_held", alu_a_o, 32'h11);
    cyc();
    chk("bp_i0_stable", alu_a_o, 32'h11);
    chk("bp_i0_valid", {31'b0, out_valid_o}, 32'd1);
    out_ready_i = 1'b1;
    cyc();
    chk("bp_i1_a", alu_a_o, 32'h22);
    chk("bp_i1_rd", {27'b0, out_rd_o}, 32'd2);
    chk("bp_ready_back", {31'b0, in_ready_o}, 32'd1);
    cyc();
    chk("bp_empty", {31'b0, out_valid_o}, 32'd0);

    // forwarding into a held entry
    out_ready_i = 1'b0;
    issue(5'd0, 5'd3, 32'h0, 5'd8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd3);
    cyc();
    in_valid_i = 1'b0;
    chk("fwd_stale", alu_a_o, 32'h0);
    wb_en_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'h55;
    cyc();
    wb_en_i = 1'b0;
    chk("fwd_held_a", alu_a_o, 32'h55);
    drain();
    out_ready_i = 1'b0;
    issue(5'd0, 5'd0, 32'h12, 5'd8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd3);
    cyc();
    in_valid_i = 1'b0;
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'h99;
    cyc();
    wb_en_i = 1'b0;
    chk("fwd_x0_a", alu_a_o, 32'h12);
    drain();

    // capture bypass
    issue(5'd0, 5'd1, 32'h0, 5'd9, 32'd1, 1'b0, 32'h0, 1'b0, 32'h0, 5'd9);
    wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'd2;
    cyc();
    in_valid_i = 1'b0; wb_en_i = 1'b0;
    chk("cap_bypass_b", alu_b_o, 32'd2);
    drain();

    // flush with both entries full
    out_ready_i = 1'b0;
    issue(5'd1, 5'd1, 32'h31, 5'd2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1);
    cyc();
    issue(5'd2, 5'd1, 32'h32, 5'd2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd2);
    cyc();
    flush_i = 1'b1;
    cyc();
    chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
    chk("flush_ready", {31'b0, in_ready_o}, 32'd1);
    // flush beats a real accept
    cyc();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_accept_dropped", {31'b0, out_valid_o}, 32'd0);

    // reset mid-stream, with concurrent flush
    issue(5'd1, 5'd1, 32'h41, 5'd2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd1);
    cyc();
    cyc();
    in_valid_i = 1'b0;
    rst_n = 1'b0; flush_i = 1'b1;
    cyc();
    chk("midrst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("midrst_a", alu_a_o, 32'd0);
    chk("midrst_ready", {31'b0, in_ready_o}, 32'd0);
    rst_n = 1'b1; flush_i = 1'b0;
    cyc();

    // randomized traffic, small register range to provoke forwarding
    repeat (4000) begin
      in_valid_i    = ($urandom % 4) != 0;
      in_alu_op_i   = 5'($urandom);
      in_rs1_addr_i = 5'($urandom_range(0, 3));
      in_rs2_addr_i = 5'($urandom_range(0, 3));
      in_rs1_data_i = $urandom;
      in_rs2_data_i = $urandom;
      in_pc_i       = $urandom;
      in_imm_i      = $urandom;
      in_a_sel_i    = 1'($urandom);
      in_b_sel_i    = 1'($urandom);
      in_rd_i       = 5'($urandom);
      wb_en_i       = 1'($urandom);
      wb_addr_i     = 5'($urandom_range(0, 3));
      wb_data_i     = $urandom;
      out_ready_i   = ($urandom % 3) != 0;
      flush_i       = ($urandom % 50) == 0;
      rst_n         = ($urandom % 300) != 0;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
